// File: rtl/hpp_mem_pkg.sv
// Shared M10K reader types, defaults and address helper.
// Used by m10k_stream_reader and rd_skid_fifo.
package hpp_mem_pkg;

  localparam int DATA_W = 10;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 640;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } rd_state_t;

  function automatic logic [ADDR_W-1:0] wrap_inc(
    input logic [ADDR_W-1:0] a,
    input logic [ADDR_W-1:0] last
  );
    return (a == last) ? '0 : a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry skid FIFO holding {last, data} read words.
// Absorbs the one-cycle M10K read latency under backpressure.
module rd_skid_fifo
  import hpp_mem_pkg::*;
#(
  parameter int W = hpp_mem_pkg::DATA_W + 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [1:0]   o_count,
  output logic [W-1:0] o_head,
  output logic         o_valid
);

  logic [W-1:0] r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_count;
  logic         w_pop;

  assign w_pop   = i_pop & (r_count != 2'd0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rptr];
  assign o_valid = (r_count != 2'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_din;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      r_count <= r_count + {1'b0, i_push} - {1'b0, w_pop};
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!reset_n)
    !(i_push && !w_pop && (r_count == 2'd2))
  );

endmodule

// File: rtl/m10k_stream_reader.sv
// Scans an M10K address window onto a valid/ready stream.
// Optional clear-on-read: define M10K_READER_CLEAR_ON_READ_EN.
module m10k_stream_reader
  import hpp_mem_pkg::*;
#(
  parameter int DATA_W = hpp_mem_pkg::DATA_W,
  parameter int ADDR_W = hpp_mem_pkg::ADDR_W,
  parameter int DEPTH  = hpp_mem_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              we
);

  localparam logic [ADDR_W-1:0] LAST_A =
    ADDR_W'(DEPTH - 1);

  rd_state_t         r_state;
  rd_state_t         w_state_nxt;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_issue_cnt;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_inflight;
  logic              r_inflight_last;
  logic              r_done_scan;
  logic              r_done_zero;

  logic              w_load;
  logic              w_zero;
  logic              w_issue;
  logic              w_fin;
  logic              w_pop;
  logic              w_room;
  logic              w_is_last;
  logic [1:0]        w_count;
  logic [DATA_W:0]   w_head;
  logic              w_valid;

  assign busy      = (r_state != IDLE) | r_done_scan;
  assign done      = r_done_scan | r_done_zero;
  assign rd_addr   = r_rd_addr;
  assign out_valid = w_valid;
  assign out_data  = w_head[DATA_W-1:0];
  assign out_last  = w_valid & w_head[DATA_W];
  assign w_pop     = w_valid & out_ready;
  assign w_is_last = (r_issue_cnt + ADDR_W'(1)) == r_len;

  // Slots already claimed (held + in flight) must leave room after pop.
  assign w_room =
    (3'(w_count) + 3'(r_inflight)) < (3'd2 + 3'(w_pop));

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_zero      = 1'b0;
    w_issue     = 1'b0;
    w_fin       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start && !busy) begin
          if (len != '0) begin
            w_load      = 1'b1;
            w_state_nxt = RUN;
          end else begin
            w_zero = 1'b1;
          end
        end
      end
      RUN: begin
        if ((r_issue_cnt < r_len) && w_room) begin
          w_issue = 1'b1;
          if (w_is_last) w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_pop && w_head[DATA_W]) begin
          w_fin       = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_len           <= '0;
      r_issue_cnt     <= '0;
      r_rd_addr       <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_done_scan     <= 1'b0;
      r_done_zero     <= 1'b0;
    end else begin
      r_done_scan     <= w_fin;
      r_done_zero     <= w_zero;
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue & w_is_last;
      if (w_load) begin
        r_len       <= len;
        r_issue_cnt <= '0;
        r_rd_addr   <= start_addr;
      end else if (w_issue) begin
        r_issue_cnt <= r_issue_cnt + ADDR_W'(1);
        r_rd_addr   <= wrap_inc(r_rd_addr, LAST_A);
      end
    end
  end

  rd_skid_fifo #(
    .W (DATA_W + 1)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (r_inflight),
    .i_pop   (w_pop),
    .i_din   ({r_inflight_last, rd_data}),
    .o_count (w_count),
    .o_head  (w_head),
    .o_valid (w_valid)
  );

`ifdef M10K_READER_CLEAR_ON_READ_EN
  logic [ADDR_W-1:0] r_inflight_addr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_inflight_addr <= '0;
    end else begin
      r_inflight_addr <= r_rd_addr;
    end
  end

  assign we      = r_inflight;
  assign wr_addr = r_inflight ? r_inflight_addr : '0;
  assign wr_data = '0;
`else
  assign we      = 1'b0;
  assign wr_addr = '0;
  assign wr_data = '0;
`endif

endmodule

// File: tb/tb_m10k_stream_reader.sv
// Directed self-checking bench for m10k_stream_reader.
// Define M10K_READER_CLEAR_ON_READ_EN to exercise clear-on-read.
module tb_m10k_stream_reader;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] start_addr = '0;
  logic [9:0] len = '0;
  logic       busy, done, out_valid, out_last, we;
  logic       out_ready = 1'b1;
  logic [9:0] rd_addr, rd_data, out_data, wr_addr, wr_data;

  logic [9:0] mem [640];

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int q_data[$];
  int q_last[$];
  int q_cyc[$];
  int wa[$];
  int wd[$];
  int n_done = 0;
  int n_valid = 0;
  int n_unstable = 0;
  int n_ovf = 0;
  int n_we = 0;
  bit p_stall = 0;
  logic [9:0] p_data;
  logic p_last;

  m10k_stream_reader dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .start_addr(start_addr), .len(len),
    .busy(busy), .done(done), .rd_addr(rd_addr),
    .rd_data(rd_data), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .wr_addr(wr_addr),
    .wr_data(wr_data), .we(we)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rd_data <= mem[rd_addr];
    if (we) mem[wr_addr] <= wr_data;
  end

  always @(negedge clk) begin
    if (done) n_done++;
    if (reset_n) begin
      if (p_stall && !(out_valid && out_data == p_data
                       && out_last == p_last))
        n_unstable++;
      p_stall = out_valid && !out_ready;
      p_data = out_data;
      p_last = out_last;
      if (out_valid) n_valid++;
      if (dut.u_fifo.r_count > 2'd2) n_ovf++;
      if (we) begin
        n_we++;
        wa.push_back(int'(wr_addr));
        wd.push_back(int'(wr_data));
      end
      if (out_valid && out_ready) begin
        q_data.push_back(int'(out_data));
        q_last.push_back(int'(out_last));
        q_cyc.push_back(cyc);
      end
    end else begin
      p_stall = 0;
    end
  end

  task automatic clear_mon();
    q_data.delete(); q_last.delete(); q_cyc.delete();
    wa.delete(); wd.delete();
    n_valid = 0; n_unstable = 0; n_we = 0;
  endtask

  task automatic pulse_start(input int a, input int l,
                             output int k);
    @(posedge clk); #1;
    start = 1'b1;
    start_addr = 10'(a);
    len = 10'(l);
    k = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    n_total++;
    if ({busy, done, out_valid, out_last, we} !== 5'b0)
      $display("FAIL reset_ctl got=%b want=00000",
               {busy, done, out_valid, out_last, we});
    else n_pass++;
    n_total++;
    if (rd_addr !== 10'd0)
      $display("FAIL reset_rd_addr got=%0d want=0", rd_addr);
    else n_pass++;
    n_total++;
    if (out_data !== 10'd0)
      $display("FAIL reset_out_data got=%0d want=0", out_data);
    else n_pass++;
    n_total++;
    if ({wr_addr, wr_data} !== 20'd0)
      $display("FAIL reset_wr got=%0d/%0d want=0/0",
               wr_addr, wr_data);
    else n_pass++;
  endtask

  task automatic test_basic();
    int k;
    bit ok;
    int e[4] = '{5, 6, 7, 8};
    clear_mon();
    out_ready = 1'b1;
    pulse_start(5, 4, k);
    n_total++;
    if (busy !== 1'b1)
      $display("FAIL basic_busy_rise got=%b want=1", busy);
    else n_pass++;
    wait_done(ok);
    n_total++;
    if (!ok) $display("FAIL basic_done_timeout got=0 want=1");
    else n_pass++;
    n_total++;
    if (q_data.size() != 4)
      $display("FAIL basic_count got=%0d want=4", q_data.size());
    else n_pass++;
    for (int i = 0; i < 4 && i < q_data.size(); i++) begin
      n_total++;
      if (q_data[i] != e[i] || q_last[i] != (i == 3 ? 1 : 0)
          || q_cyc[i] != k + 3 + i)
        $display("FAIL basic_beat%0d got=%0d/%0d@%0d want=%0d/%0d@%0d",
                 i, q_data[i], q_last[i], q_cyc[i],
                 e[i], (i == 3 ? 1 : 0), k + 3 + i);
      else n_pass++;
    end
    n_total++;
    if (cyc != k + 7 || busy !== 1'b1)
      $display("FAIL basic_done_cyc got=%0d/%b want=%0d/1",
               cyc, busy, k + 7);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({busy, done} !== 2'b00)
      $display("FAIL basic_after_done got=%b want=00", {busy, done});
    else n_pass++;
  endtask

  task automatic test_wrap();
    int k;
    bit ok;
    int e[4] = '{638, 639, 0, 1};
    clear_mon();
    pulse_start(638, 4, k);
    wait_done(ok);
    n_total++;
    if (!ok || q_data.size() != 4)
      $display("FAIL wrap_count got=%0d want=4", q_data.size());
    else n_pass++;
    for (int i = 0; i < 4 && i < q_data.size(); i++) begin
      n_total++;
      if (q_data[i] != e[i])
        $display("FAIL wrap_beat%0d got=%0d want=%0d",
                 i, q_data[i], e[i]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int k;
    bit ok;
    logic pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    clear_mon();
    pulse_start(100, 3, k);
    for (int i = 0; i < 6; i++) begin
      out_ready = pat[i];
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_done(ok);
    n_total++;
    if (!ok || q_data.size() != 3)
      $display("FAIL bp_count got=%0d want=3", q_data.size());
    else n_pass++;
    for (int i = 0; i < 3 && i < q_data.size(); i++) begin
      n_total++;
      if (q_data[i] != 100 + i || q_last[i] != (i == 2 ? 1 : 0))
        $display("FAIL bp_beat%0d got=%0d/%0d want=%0d/%0d",
                 i, q_data[i], q_last[i], 100 + i, (i == 2 ? 1 : 0));
      else n_pass++;
    end
    n_total++;
    if (n_unstable != 0)
      $display("FAIL bp_stable got=%0d want=0", n_unstable);
    else n_pass++;
    n_total++;
    if (n_ovf != 0)
      $display("FAIL bp_fifo_count got=%0d want=0", n_ovf);
    else n_pass++;
  endtask

  task automatic test_zero_len();
    int k;
    int k2;
    bit ok;
    clear_mon();
    pulse_start(0, 0, k);
    n_total++;
    if ({done, busy} !== 2'b10)
      $display("FAIL zero_done got=%b want=10", {done, busy});
    else n_pass++;
    repeat (4) @(negedge clk);
    n_total++;
    if (n_valid != 0 || done !== 1'b0)
      $display("FAIL zero_no_valid got=%0d/%b want=0/0",
               n_valid, done);
    else n_pass++;
    clear_mon();
    pulse_start(20, 2, k);
    pulse_start(300, 5, k2);
    wait_done(ok);
    repeat (8) @(negedge clk);
    n_total++;
    if (!ok || q_data.size() != 2)
      $display("FAIL busy_ignore_count got=%0d want=2",
               q_data.size());
    else n_pass++;
    n_total++;
    if (q_data.size() < 2 || q_data[0] != 20 || q_data[1] != 21)
      $display("FAIL busy_ignore_data got=%0d want=20,21",
               q_data.size() > 0 ? q_data[0] : -1);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int k;
    int nd0;
    bit ok;
    clear_mon();
    pulse_start(200, 6, k);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (q_data.size() >= 2) begin
        ok = 1;
        break;
      end
    end
    n_total++;
    if (!ok) $display("FAIL rst_mid_beats got=%0d want=2",
                      q_data.size());
    else n_pass++;
    nd0 = n_done;
    #2 reset_n = 1'b0;
    #1;
    n_total++;
    if ({busy, done, out_valid, out_last, we} !== 5'b0
        || rd_addr !== 10'd0 || out_data !== 10'd0)
      $display("FAIL rst_mid_async got=%b/%0d/%0d want=0/0/0",
               {busy, done, out_valid, out_last, we},
               rd_addr, out_data);
    else n_pass++;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if (n_done != nd0)
      $display("FAIL rst_mid_no_done got=%0d want=%0d",
               n_done, nd0);
    else n_pass++;
    clear_mon();
    pulse_start(50, 3, k);
    wait_done(ok);
    n_total++;
    if (!ok || q_data.size() != 3 || q_data[0] != 50
        || q_data[1] != 51 || q_data[2] != 52 || q_last[2] != 1)
      $display("FAIL rst_mid_rescan got=%0d beats want=50,51,52",
               q_data.size());
    else n_pass++;
  endtask

  task automatic test_clear();
    int k;
    bit ok;
    clear_mon();
    pulse_start(10, 2, k);
    wait_done(ok);
`ifdef M10K_READER_CLEAR_ON_READ_EN
    n_total++;
    if (!ok || wa.size() != 2 || wa[0] != 10 || wa[1] != 11
        || wd[0] != 0 || wd[1] != 0)
      $display("FAIL clear_we got=%0d writes want=10,11 data 0",
               wa.size());
    else n_pass++;
    clear_mon();
    pulse_start(10, 2, k);
    wait_done(ok);
    n_total++;
    if (!ok || q_data.size() != 2 || q_data[0] != 0
        || q_data[1] != 0)
      $display("FAIL clear_rescan got=%0d beats want=0,0",
               q_data.size());
    else n_pass++;
`else
    n_total++;
    if (n_we != 0)
      $display("FAIL clear_off_we got=%0d want=0", n_we);
    else n_pass++;
    n_total++;
    if (!ok || q_data.size() != 2 || q_data[0] != 10
        || q_data[1] != 11)
      $display("FAIL clear_off_data got=%0d beats want=10,11",
               q_data.size());
    else n_pass++;
`endif
  endtask

  initial begin
    for (int i = 0; i < 640; i++) mem[i] = 10'(i);
    rd_data = '0;
    #12;
    test_reset();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_reset_mid();
    test_clear();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/m10k_stream_reader.md
Name: m10k_stream_reader

Overview:
- Read-side engine for a simple dual-port M10K buffer with 1-cycle registered read (q valid the cycle after read_address is presented).
- Scans a programmed address window and emits each word on a valid/ready stream, e.g. toward the VGA/compute pipeline.
- Absorbs the fixed read latency under downstream backpressure with a 2-entry skid FIFO, sustaining 1 word/cycle when out_ready stays high.

Parameters:
- DATA_W, 10, word width; matches the M10K q/d width.
- ADDR_W, 10, address width.
- DEPTH, 640, number of words; addresses wrap modulo DEPTH.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches start_addr and len. Ignored while busy=1.
- start_addr  in  ADDR_W  first address; must be < DEPTH.
- len  in  ADDR_W  word count, 0..DEPTH.
- busy  out  1  high from the cycle after start until the cycle done pulses, inclusive.
- done  out  1  one-cycle pulse at the end of a scan.
- rd_addr  out  ADDR_W  registered read address to M10K read_address.
- rd_data  in  DATA_W  M10K q.
- out_data  out  DATA_W  stream payload; driven from the FIFO head.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_last  out  1  marks the final word of a scan.
- wr_addr  out  ADDR_W  clear-write address (see Optional Feature).
- wr_data  out  DATA_W  clear-write data.
- we  out  1  clear-write enable.

Behaviour:
- Reset values: busy=0, done=0, rd_addr=0, out_valid=0, out_data=0, out_last=0, we=0, wr_addr=0, wr_data=0. The FIFO, counters and inflight flag are cleared.
- Reset mid-scan: the scan is abandoned and no done pulse is produced.
- FSM IDLE -> RUN -> DRAIN -> IDLE.
- IDLE:
  - start with len>0 -> RUN, with issue_cnt=0 and beat_cnt=0.
  - start with len=0 -> done pulses the next cycle, busy stays 0, no beats, remain IDLE.
- Issue rule: in RUN, a read issues in cycle t when issue_cnt<len and fifo_count + inflight - pop < 2. Here pop = out_valid & out_ready, and inflight = a read issued in cycle t-1.
- Issued read:
  - rd_addr (registered) holds address A during cycle t.
  - rd_data is valid in cycle t+1 and is pushed into the FIFO at the end of t+1.
  - rd_addr then advances to A+1; it wraps to 0 when A = DEPTH-1.
- When issue_cnt reaches len: RUN -> DRAIN.
- Beat handshake:
  - A beat transfers when out_valid & out_ready; beat_cnt increments.
  - out_last = out_valid & (beat_cnt == len-1).
- DRAIN -> IDLE on the cycle the last beat transfers. done pulses and busy drops on the following cycle.
- Simultaneous push and pop: FIFO count unchanged; data order preserved.
- The FIFO never overflows; overflow is an assertion failure.
- out_data/out_valid are stable while out_valid=1 & out_ready=0.
- Steady state with out_ready=1: first beat 2 cycles after the first issue, then 1 beat per cycle.
- rd_addr may keep its last value after a scan; the M10K read has no side effects.

Optional Feature:
- Macro: M10K_READER_CLEAR_ON_READ_EN.
- Defined: when each word is pushed into the FIFO, the same cycle drives we=1, wr_addr=A, wr_data=0. This clears the cell for the next automaton generation; the dual-port M10K permits the concurrent write.
- Undefined: we, wr_addr and wr_data are held at 0 and there is no clear logic.

Decomposition:
- Package hpp_mem_pkg holds:
  - DATA_W, ADDR_W and DEPTH defaults.
  - the reader FSM state enum {IDLE, RUN, DRAIN}.
  - a wrap-increment helper function.
- Sub-module rd_skid_fifo: 2-entry DATA_W+1 FIFO (data + last) with push, pop, count and head outputs.

Test Plan:
- start_addr=5, len=4, out_ready=1, memory preloaded mem[i]=i -> out_data 5,6,7,8 on consecutive cycles, out_last on 8, done 1 cycle after the last beat.
- start_addr=638, len=4 -> beats 638, 639, 0, 1 (wrap).
- len=3 with out_ready toggling 1,0,0,1,0,1 -> no beat lost or duplicated, data held stable while stalled, FIFO count never exceeds 2.
- len=0 -> done the next cycle, no out_valid; a start while busy is ignored (no extra beats).
- reset_n deasserted mid-scan at beat 2 of 6 -> all outputs return to reset values asynchronously, no done; a fresh scan afterwards completes correctly.
- With M10K_READER_CLEAR_ON_READ_EN, start_addr=10, len=2 -> we pulses with wr_addr=10 then 11, wr_data=0; a rescan reads 0,0.
